tape_player: RTL and testbench

Plays a cassette image from SDRAM into the Laser 500 cassette input, so software can LOAD without an external tape source. The block reads the image bytes that the downloader has already written to SDRAM, one byte at a time, through the SDRAM read arbiter. It serialises each byte MSB-first into the FSK waveform expected by the ROM tape routine. Its `casin` output is ORed (after the level select) with the `UART_RX`-derived CASIN feeding the VTL chip and the audio DAC.

---
 rtl/laser500_pkg.sv | 19 +
 rtl/tape_bit_encoder.sv | 74 +++++++
 rtl/tape_player.sv | 199 +++++++++++++++++++
 tb/tb_tape_player.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/laser500_pkg.sv
// Shared definitions for the Laser 500 cassette playback path.
package laser500_pkg;

  // Master clock frequency of the F14M domain.
  localparam int F14M_HZ = 14_700_000;

  // Half-period lengths in F14M ticks: 250 us (short) and 500 us (long).
  localparam int SHORT_HALF_DEFAULT = 3675;
  localparam int LONG_HALF_DEFAULT  = 7350;

  // Playback controller states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FIRST = 2'd1,
    PLAY  = 2'd2,
    STALL = 2'd3
  } tape_state_t;

endpackage

// File: rtl/tape_bit_encoder.sv
// FSK bit encoder: bit 1 = four short halves (H,L,H,L), bit 0 = two long
// halves (H,L). The bit value is taken live from bit_val, which the caller
// keeps stable for the whole bit. bit_done is high in the last cycle of a
// bit; if bit_valid is still high the next bit starts on that edge, so
// consecutive bits are contiguous.
module tape_bit_encoder
  import laser500_pkg::*;
#(
  parameter int SHORT_HALF = SHORT_HALF_DEFAULT,
  parameter int LONG_HALF  = LONG_HALF_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic bit_valid,
  input  logic bit_val,
  output logic level,
  output logic bit_done
);

  localparam int CW = $clog2(LONG_HALF + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    half_q, half_d;
  logic          busy_q, busy_d;
  logic          half_end;

  // Half-period end, bit end and output level decode.
  always_comb begin
    half_end = 1'b0;
    if (busy_q) begin
      half_end = bit_val ? (cnt_q == CW'(SHORT_HALF - 1))
                         : (cnt_q == CW'(LONG_HALF - 1));
    end
    bit_done = bit_valid && half_end &&
               (bit_val ? (half_q == 2'd3) : (half_q == 2'd1));
    // Even halves are high; level is forced low whenever no bit is offered.
    level    = bit_valid && busy_q && !half_q[0];
  end

  // Next-state for the half counter and half index.
  always_comb begin
    busy_d = busy_q;
    half_d = half_q;
    cnt_d  = cnt_q;
    if (!bit_valid) begin
      busy_d = 1'b0;
      half_d = 2'd0;
      cnt_d  = '0;
    end else if (!busy_q) begin
      busy_d = 1'b1;
      half_d = 2'd0;
      cnt_d  = '0;
    end else if (half_end) begin
      cnt_d  = '0;
      half_d = bit_done ? 2'd0 : half_q + 2'd1;
    end else begin
      cnt_d  = cnt_q + CW'(1);
    end
  end

  // Encoder registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      half_q <= 2'd0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      half_q <= half_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/tape_player.sv
// Cassette image player: fetches image bytes from SDRAM and serialises them
// MSB-first into the FSK tape waveform on casin.
//
// Read handshake: rd_req is a request that stays high, with rd_addr stable,
// until a cycle in which rd_ack is high; rd_data is valid in that cycle and
// the transfer completes on that edge. An rd_ack while rd_req is low is
// ignored, so acks that arrive after a stop are dropped.
module tape_player
  import laser500_pkg::*;
#(
  parameter logic [24:0] BASE_ADDR  = 25'h0100000,
  parameter int          SHORT_HALF = SHORT_HALF_DEFAULT,
  parameter int          LONG_HALF  = LONG_HALF_DEFAULT,
  parameter int          LEN_W      = 24
) (
  input  logic             F14M,
  input  logic             RESET,
  input  logic             start,
  input  logic             stop,
  input  logic [LEN_W-1:0] length,
  output logic             rd_req,
  output logic [24:0]      rd_addr,
  input  logic             rd_ack,
  input  logic [7:0]       rd_data,
  output logic             casin,
  output logic             playing,
  output logic             done,
  output logic             underrun,
  output logic [LEN_W-1:0] byte_count,
  output tape_state_t      dbg_state
);

  tape_state_t      state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] fetched_q, fetched_d;
  logic [LEN_W-1:0] count_q, count_d;
  logic [LEN_W-1:0] count_inc;
  logic [24:0]      ptr_q, ptr_d;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic             underrun_q, underrun_d;
  logic             done_q, done_d;
  logic             ack_ok;
  logic             bit_done;
  logic             enc_level;

  tape_bit_encoder #(
    .SHORT_HALF (SHORT_HALF),
    .LONG_HALF  (LONG_HALF)
  ) u_enc (
    .clk       (F14M),
    .rst       (RESET),
    .bit_valid (state_q == PLAY),
    .bit_val   (shift_q[7]),
    .level     (enc_level),
    .bit_done  (bit_done)
  );

  // Read request: byte 0 fetch, stall refill, or prefetch into an empty buffer.
  always_comb begin
    rd_req = 1'b0;
    case (state_q)
      FIRST, STALL: rd_req = 1'b1;
      PLAY:         rd_req = !hold_full_q && (fetched_q != len_q);
      default:      rd_req = 1'b0;
    endcase
  end

  assign ack_ok     = rd_ack && rd_req;
  assign rd_addr    = ptr_q;
  assign count_inc  = count_q + LEN_W'(1);
  assign casin      = enc_level;
  assign playing    = (state_q != IDLE);
  assign done       = done_q;
  assign underrun   = underrun_q;
  assign byte_count = count_q;
  assign dbg_state  = state_q;

  // Playback FSM next-state, buffer and counter updates.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    fetched_d   = fetched_q;
    count_d     = count_q;
    ptr_d       = ptr_q;
    shift_d     = shift_q;
    bit_idx_d   = bit_idx_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    underrun_d  = underrun_q;
    done_d      = 1'b0;
    if (stop) begin
      // Abort wins over everything, including a simultaneous start.
      state_d     = IDLE;
      hold_full_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (length == '0) begin
              done_d = 1'b1;
            end else begin
              state_d     = FIRST;
              len_d       = length;
              ptr_d       = BASE_ADDR;
              fetched_d   = '0;
              count_d     = '0;
              underrun_d  = 1'b0;
              hold_full_d = 1'b0;
            end
          end
        end
        FIRST: begin
          if (ack_ok) begin
            shift_d   = rd_data;
            bit_idx_d = 3'd7;
            ptr_d     = ptr_q + 25'd1;
            fetched_d = fetched_q + LEN_W'(1);
            state_d   = PLAY;
          end
        end
        PLAY: begin
          if (ack_ok) begin
            hold_d      = rd_data;
            hold_full_d = 1'b1;
            ptr_d       = ptr_q + 25'd1;
            fetched_d   = fetched_q + LEN_W'(1);
          end
          if (bit_done) begin
            if (bit_idx_q != 3'd0) begin
              shift_d   = {shift_q[6:0], 1'b0};
              bit_idx_d = bit_idx_q - 3'd1;
            end else begin
              count_d = count_inc;
              if (count_inc == len_q) begin
                done_d  = 1'b1;
                state_d = IDLE;
              end else if (hold_full_q) begin
                shift_d     = hold_q;
                hold_full_d = 1'b0;
                bit_idx_d   = 3'd7;
              end else if (ack_ok) begin
                // Byte arrives exactly on the boundary: play it straight away.
                shift_d     = rd_data;
                hold_full_d = 1'b0;
                bit_idx_d   = 3'd7;
              end else begin
                underrun_d = 1'b1;
                state_d    = STALL;
              end
            end
          end
        end
        STALL: begin
          if (ack_ok) begin
            shift_d   = rd_data;
            bit_idx_d = 3'd7;
            ptr_d     = ptr_q + 25'd1;
            fetched_d = fetched_q + LEN_W'(1);
            state_d   = PLAY;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Controller registers.
  always_ff @(posedge F14M or posedge RESET) begin
    if (RESET) begin
      state_q     <= IDLE;
      len_q       <= '0;
      fetched_q   <= '0;
      count_q     <= '0;
      ptr_q       <= '0;
      shift_q     <= '0;
      bit_idx_q   <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      underrun_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      fetched_q   <= fetched_d;
      count_q     <= count_d;
      ptr_q       <= ptr_d;
      shift_q     <= shift_d;
      bit_idx_q   <= bit_idx_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      underrun_q  <= underrun_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_tape_player.sv
// Directed bench for tape_player with a small SDRAM arbiter model.
module tb_tape_player;
  import laser500_pkg::*;

  localparam int          SH    = 4;
  localparam int          LH    = 8;
  localparam int          LEN_W = 24;
  localparam logic [24:0] BASE  = 25'h0100000;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic [LEN_W-1:0] length = '0;
  logic             rd_req;
  logic [24:0]      rd_addr;
  logic             rd_ack = 1'b0;
  logic [7:0]       rd_data = 8'h00;
  logic             casin;
  logic             playing;
  logic             done;
  logic             underrun;
  logic [LEN_W-1:0] byte_count;
  tape_state_t      dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int rise_cyc = 0;

  // Arbiter model state (written only by the arbiter process).
  logic [7:0]  mem [0:15];
  logic [24:0] got_q[$];
  logic [24:0] exp_q[$];
  logic        arb_busy = 1'b0;
  int          arb_cnt = 0;
  logic [24:0] arb_addr = '0;
  int          req_total = 0;
  int          ack_n = 0;
  int          ack_cyc = 0;
  int          n_done = 0;

  // Scenario knobs (written only by the stimulus process).
  int scen_base = 0;
  int slow_k = 99;
  int slow_delay = 3;

  tape_player #(
    .BASE_ADDR  (BASE),
    .SHORT_HALF (SH),
    .LONG_HALF  (LH),
    .LEN_W      (LEN_W)
  ) dut (
    .F14M       (clk),
    .RESET      (rst),
    .start      (start),
    .stop       (stop),
    .length     (length),
    .rd_req     (rd_req),
    .rd_addr    (rd_addr),
    .rd_ack     (rd_ack),
    .rd_data    (rd_data),
    .casin      (casin),
    .playing    (playing),
    .done       (done),
    .underrun   (underrun),
    .byte_count (byte_count),
    .dbg_state  (dbg_state)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Arbiter: accepts a request, answers after a delay with a one-cycle ack.
  always @(negedge clk) begin
    rd_ack = 1'b0;
    if (arb_busy) begin
      if (arb_cnt <= 1) begin
        rd_ack   = 1'b1;
        rd_data  = mem[4'(arb_addr - BASE)];
        arb_busy = 1'b0;
        ack_cyc  = cyc;
        ack_n++;
      end else begin
        arb_cnt--;
      end
    end else if (rd_req) begin
      arb_busy = 1'b1;
      arb_cnt  = ((req_total - scen_base) == slow_k) ? slow_delay : 3;
      arb_addr = rd_addr;
      got_q.push_back(rd_addr);
      req_total++;
    end
  end

  // done pulse counter.
  always @(negedge clk) if (done) n_done++;

  // Watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_start(input logic [LEN_W-1:0] len);
    scen_base = req_total;
    start  = 1'b1;
    length = len;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic wait_rise(input string tag);
    int t;
    t = 0;
    while (casin !== 1'b1 && t < 500) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_rise_seen"}, 32'(t < 500), 32'd1);
    rise_cyc = cyc;
  endtask

  // Waits for the first rise, then checks every cycle of the expected
  // waveform for nbytes bytes packed first-byte-highest in bytes.
  task automatic check_wave(input string tag, input logic [23:0] bytes,
                            input int nbytes, input logic expect_done);
    int errs;
    int hl;
    int nh;
    logic bv;
    errs = 0;
    wait_rise(tag);
    for (int by = 0; by < nbytes; by++) begin
      for (int bi = 7; bi >= 0; bi--) begin
        bv = bytes[(nbytes - 1 - by) * 8 + bi];
        hl = bv ? SH : LH;
        nh = bv ? 4 : 2;
        for (int h = 0; h < nh; h++) begin
          for (int c = 0; c < hl; c++) begin
            if (casin !== ((h % 2) == 0)) errs++;
            if (expect_done && done) errs++;
            @(negedge clk);
          end
        end
      end
    end
    check({tag, "_wave_errs"}, 32'(errs), 32'd0);
    check({tag, "_done_at_end"}, 32'(done), 32'(expect_done));
    check({tag, "_playing_at_end"}, 32'(playing), 32'(!expect_done));
    check({tag, "_casin_at_end"}, 32'(casin), 32'd0);
  endtask

  initial begin
    int d0;
    int hi;
    int a0;
    // Reset state.
    @(negedge clk);
    check("rst_casin", 32'(casin), 32'd0);
    check("rst_playing", 32'(playing), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    check("rst_byte_count", 32'(byte_count), 32'd0);
    check("rst_rd_req", 32'(rd_req), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Scenario 1: single byte A5.
    mem[0] = 8'hA5;
    d0 = n_done;
    do_start(24'd1);
    check("s1_rd_req_after_start", 32'(rd_req), 32'd1);
    check("s1_playing_after_start", 32'(playing), 32'd1);
    exp_q.push_back(BASE);
    check_wave("s1", 24'h0000A5, 1, 1'b1);
    check("s1_rise_after_ack", 32'(rise_cyc - ack_cyc), 32'd2);
    check("s1_byte_count", 32'(byte_count), 32'd1);
    check("s1_underrun", 32'(underrun), 32'd0);
    repeat (3) @(negedge clk);
    check("s1_done_pulses", 32'(n_done - d0), 32'd1);

    // Scenario 2: three bytes 00, FF, 81 back to back.
    mem[0] = 8'h00; mem[1] = 8'hFF; mem[2] = 8'h81;
    d0 = n_done;
    a0 = ack_n;
    do_start(24'd3);
    exp_q.push_back(BASE); exp_q.push_back(BASE + 25'd1); exp_q.push_back(BASE + 25'd2);
    check_wave("s2", 24'h00FF81, 3, 1'b1);
    check("s2_byte_count", 32'(byte_count), 32'd3);
    check("s2_underrun", 32'(underrun), 32'd0);
    repeat (10) @(negedge clk);
    check("s2_acks", 32'(ack_n - a0), 32'd3);
    check("s2_done_pulses", 32'(n_done - d0), 32'd1);

    // Scenario 3: zero length.
    d0 = n_done;
    do_start(24'd0);
    check("s3_done_next", 32'(done), 32'd1);
    check("s3_playing", 32'(playing), 32'd0);
    hi = 0;
    repeat (10) begin
      if (rd_req || playing) hi++;
      @(negedge clk);
    end
    check("s3_rd_req_cycles", 32'(hi), 32'd0);
    check("s3_done_pulses", 32'(n_done - d0), 32'd1);

    // Scenario 4: slow ack for byte 1 forces a stall.
    mem[0] = 8'hF0; mem[1] = 8'h3C;
    slow_k = 1; slow_delay = 200;
    do_start(24'd2);
    exp_q.push_back(BASE); exp_q.push_back(BASE + 25'd1);
    check_wave("s4b0", 24'h0000F0, 1, 1'b0);
    check("s4_underrun", 32'(underrun), 32'd1);
    check("s4_playing_stall", 32'(playing), 32'd1);
    check("s4_rd_req_stall", 32'(rd_req), 32'd1);
    check_wave("s4b1", 24'h00003C, 1, 1'b1);
    check("s4_rise_after_ack", 32'(rise_cyc - ack_cyc), 32'd2);
    check("s4_byte_count", 32'(byte_count), 32'd2);
    check("s4_underrun_sticky", 32'(underrun), 32'd1);
    slow_k = 99;
    repeat (3) @(negedge clk);

    // Scenario 5: stop during byte 1 with a request outstanding, then replay.
    mem[0] = 8'hFF; mem[1] = 8'h00; mem[2] = 8'h00;
    slow_k = 2; slow_delay = 200;
    a0 = ack_n;
    d0 = n_done;
    do_start(24'd3);
    exp_q.push_back(BASE); exp_q.push_back(BASE + 25'd1); exp_q.push_back(BASE + 25'd2);
    wait_rise("s5");
    repeat (158) @(negedge clk);
    check("s5_byte_count_before_stop", 32'(byte_count), 32'd1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("s5_casin_after_stop", 32'(casin), 32'd0);
    check("s5_playing_after_stop", 32'(playing), 32'd0);
    check("s5_rd_req_after_stop", 32'(rd_req), 32'd0);
    hi = 0;
    repeat (250) begin
      if (casin || playing || rd_req || done) hi++;
      @(negedge clk);
    end
    check("s5_quiet_after_stop", 32'(hi), 32'd0);
    check("s5_late_ack_seen", 32'(ack_n - a0), 32'd3);
    check("s5_no_done", 32'(n_done - d0), 32'd0);
    slow_k = 99;
    mem[0] = 8'h5A;
    do_start(24'd1);
    exp_q.push_back(BASE);
    check("s5_restart_byte_count", 32'(byte_count), 32'd0);
    check("s5_restart_addr", 32'(rd_addr), 32'(BASE));
    check_wave("s5r", 24'h00005A, 1, 1'b1);
    check("s5_restart_count_end", 32'(byte_count), 32'd1);
    repeat (3) @(negedge clk);

    // Scenario 6: asynchronous reset during playback.
    mem[0] = 8'hA5; mem[1] = 8'h3C;
    do_start(24'd2);
    exp_q.push_back(BASE); exp_q.push_back(BASE + 25'd1);
    wait_rise("s6");
    repeat (138) @(negedge clk);
    check("s6_byte_count_before_rst", 32'(byte_count), 32'd1);
    d0 = n_done;
    #2 rst = 1'b1;
    #1;
    check("s6_rst_casin", 32'(casin), 32'd0);
    check("s6_rst_playing", 32'(playing), 32'd0);
    check("s6_rst_byte_count", 32'(byte_count), 32'd0);
    check("s6_rst_rd_req", 32'(rd_req), 32'd0);
    check("s6_rst_done", 32'(done), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("s6_no_done", 32'(n_done - d0), 32'd0);
    mem[0] = 8'hC3;
    do_start(24'd1);
    exp_q.push_back(BASE);
    check_wave("s6r", 24'h0000C3, 1, 1'b1);
    check("s6r_byte_count", 32'(byte_count), 32'd1);
    repeat (5) @(negedge clk);

    // Request address scoreboard.
    check("addr_count", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check($sformatf("addr_%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
